// File: rtl/hy_stream_feeder.sv
// rtl/hy_stream_feeder.sv - H/Y source feeder: host-loaded 4x4 H and 8-entry Y, streamed once per q.
// All outputs registered; buffers are not cleared by rst.
module hy_stream_feeder #(
    parameter int N       = 32,
    parameter int NUM_Q   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_wr_en,
    input  logic                cfg_wr_sel,
    input  logic [3:0]          cfg_wr_addr,
    input  logic signed [N-1:0] cfg_wr_r,
    input  logic signed [N-1:0] cfg_wr_i,
    input  logic                run,
    input  logic                hold,
    input  logic                q_done,
    output logic                start_new_q,
    output logic [3:0]          q_index,
    output logic                H_in_valid,
    output logic signed [N-1:0] H_in_r,
    output logic signed [N-1:0] H_in_i,
    output logic                Y_in_valid,
    output logic signed [N-1:0] Y_in_r,
    output logic signed [N-1:0] Y_in_i,
    output logic                busy,
    output logic                all_done,
    output logic                err_timeout,
    output logic                err_early
);

    localparam int            WW     = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
    localparam logic [3:0]    Q_LAST = 4'(NUM_Q - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          q_q, q_d;
    logic [4:0]          b_q, b_d;
    logic [WW-1:0]       w_q, w_d;
    logic                busy_q, busy_d;
    logic                snq_q, snq_d;
    logic                all_done_q, all_done_d;
    logic                hv_q, hv_d, yv_q, yv_d;
    logic signed [N-1:0] hr_q, hr_d, hi_q, hi_d, yr_q, yr_d, yi_q, yi_d;
    logic                err_to_q, err_to_d, err_early_q, err_early_d;
    logic                issue;

    logic signed [N-1:0] h_r_mem [16];
    logic signed [N-1:0] h_i_mem [16];
    logic signed [N-1:0] y_r_mem [8];
    logic signed [N-1:0] y_i_mem [8];

    // Host writes are only honoured while idle so a sweep always sees one consistent H/Y set.
    always_ff @(posedge clk) begin
        if (cfg_wr_en && state_q == S_IDLE) begin
            if (!cfg_wr_sel) begin
                h_r_mem[cfg_wr_addr] <= cfg_wr_r;
                h_i_mem[cfg_wr_addr] <= cfg_wr_i;
            end else begin
                y_r_mem[cfg_wr_addr[2:0]] <= cfg_wr_r;
                y_i_mem[cfg_wr_addr[2:0]] <= cfg_wr_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        b_d         = b_q;
        w_d         = w_q;
        busy_d      = busy_q;
        snq_d       = 1'b0;
        all_done_d  = 1'b0;
        hv_d        = 1'b0;
        yv_d        = 1'b0;
        hr_d        = hr_q;
        hi_d        = hi_q;
        yr_d        = yr_q;
        yi_d        = yi_q;
        err_to_d    = err_to_q;
        err_early_d = err_early_q;
        issue       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d     = S_START;
                    busy_d      = 1'b1;
                    q_d         = 4'd0;
                    b_d         = 5'd0;
                    snq_d       = 1'b1;
                    err_to_d    = 1'b0;
                    err_early_d = 1'b0;
                end
            end
            S_START: begin
                state_d = S_STREAM;
                issue   = !hold;
            end
            S_STREAM: begin
                // b counts beats already issued; at 16 the last beat is on the outputs now.
                if (b_q == 5'd16) begin
                    state_d = S_WAIT;
                    w_d     = '0;
                end else begin
                    issue = !hold;
                end
            end
            S_WAIT: begin
                if (q_done) begin
                    if (q_q == Q_LAST) begin
                        state_d    = S_IDLE;
                        busy_d     = 1'b0;
                        all_done_d = 1'b1;
                    end else begin
                        state_d = S_START;
                        q_d     = q_q + 4'd1;
                        b_d     = 5'd0;
                        snq_d   = 1'b1;
                    end
                end else if (w_q == W_LAST) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    err_to_d = 1'b1;
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            hv_d = 1'b1;
            hr_d = h_r_mem[b_q[3:0]];
            hi_d = h_i_mem[b_q[3:0]];
            if (b_q < 5'd8) begin
                yv_d = 1'b1;
                yr_d = y_r_mem[b_q[2:0]];
                yi_d = y_i_mem[b_q[2:0]];
            end
            b_d = b_q + 5'd1;
        end

        if (q_done && state_q != S_WAIT) begin
            err_early_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            q_q         <= '0;
            b_q         <= '0;
            w_q         <= '0;
            busy_q      <= 1'b0;
            snq_q       <= 1'b0;
            all_done_q  <= 1'b0;
            hv_q        <= 1'b0;
            yv_q        <= 1'b0;
            hr_q        <= '0;
            hi_q        <= '0;
            yr_q        <= '0;
            yi_q        <= '0;
            err_to_q    <= 1'b0;
            err_early_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            b_q         <= b_d;
            w_q         <= w_d;
            busy_q      <= busy_d;
            snq_q       <= snq_d;
            all_done_q  <= all_done_d;
            hv_q        <= hv_d;
            yv_q        <= yv_d;
            hr_q        <= hr_d;
            hi_q        <= hi_d;
            yr_q        <= yr_d;
            yi_q        <= yi_d;
            err_to_q    <= err_to_d;
            err_early_q <= err_early_d;
        end
    end

    assign start_new_q = snq_q;
    assign q_index     = q_q;
    assign H_in_valid  = hv_q;
    assign H_in_r      = hr_q;
    assign H_in_i      = hi_q;
    assign Y_in_valid  = yv_q;
    assign Y_in_r      = yr_q;
    assign Y_in_i      = yi_q;
    assign busy        = busy_q;
    assign all_done    = all_done_q;
    assign err_timeout = err_to_q;
    assign err_early   = err_early_q;

endmodule

// File: tb/tb_hy_stream_feeder.sv
// tb/tb_hy_stream_feeder.sv - randomized bench for hy_stream_feeder against a per-sweep reference model.
module tb_hy_stream_feeder;

    localparam int N  = 32;
    localparam int NQ = 4;
    localparam int TO = 20;

    localparam int P_IDLE   = 0;
    localparam int P_START  = 1;
    localparam int P_STREAM = 2;
    localparam int P_WAIT   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, cfg_wr_en, cfg_wr_sel, run, hold, q_done;
    logic [3:0]          cfg_wr_addr;
    logic signed [N-1:0] cfg_wr_r, cfg_wr_i;
    logic                start_new_q, H_in_valid, Y_in_valid, busy, all_done, err_timeout, err_early;
    logic [3:0]          q_index;
    logic signed [N-1:0] H_in_r, H_in_i, Y_in_r, Y_in_i;

    hy_stream_feeder #(.N(N), .NUM_Q(NQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_r(cfg_wr_r), .cfg_wr_i(cfg_wr_i),
        .run(run), .hold(hold), .q_done(q_done),
        .start_new_q(start_new_q), .q_index(q_index),
        .H_in_valid(H_in_valid), .H_in_r(H_in_r), .H_in_i(H_in_i),
        .Y_in_valid(Y_in_valid), .Y_in_r(Y_in_r), .Y_in_i(Y_in_i),
        .busy(busy), .all_done(all_done), .err_timeout(err_timeout), .err_early(err_early)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic signed [N-1:0] m_hr [16];
    logic signed [N-1:0] m_hi [16];
    logic signed [N-1:0] m_yr [8];
    logic signed [N-1:0] m_yi [8];
    bit exp_to, exp_early;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {start_new_q, q_index, H_in_valid, Y_in_valid, busy, all_done,
                            err_timeout, err_early}, 64'd0);
        chk({tag, "_h"}, {H_in_r, H_in_i}, 64'd0);
        chk({tag, "_y"}, {Y_in_r, Y_in_i}, 64'd0);
    endtask

    task automatic cfg_write(input bit sel, input logic [3:0] a,
                             input logic signed [N-1:0] r, input logic signed [N-1:0] i);
        cfg_wr_en = 1'b1; cfg_wr_sel = sel; cfg_wr_addr = a; cfg_wr_r = r; cfg_wr_i = i;
        tick;
        cfg_wr_en = 1'b0;
        if (!sel) begin
            m_hr[a] = r; m_hi[a] = i;
        end else begin
            m_yr[a[2:0]] = r; m_yi[a[2:0]] = i;
        end
    endtask

    // One full run: the model tracks phase, q, beats seen and wait cycles; every cycle is checked.
    task automatic sweep(input int hold_pct, input bit dir_hold, input bit no_done, input bit early,
                         input int rst_q, input bit poke, input int fix_dly);
        int phase, q, hc, w, dly, held;
        bit hold_prev, qd_prev, run_prev, exp_snq, exp_ad, exp_hv, exp_yv, early_done, poked;
        phase = P_IDLE; q = 0; hc = 0; w = 0; dly = 0; held = 0;
        early_done = 1'b0; poked = 1'b0;
        run = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            hold_prev = hold; qd_prev = q_done; run_prev = run;
            tick;
            run = 1'b0; q_done = 1'b0; cfg_wr_en = 1'b0; hold = 1'b0;
            exp_snq = 1'b0; exp_ad = 1'b0; exp_hv = 1'b0;
            case (phase)
                P_IDLE: begin
                    if (run_prev) begin
                        phase = P_START; q = 0; hc = 0; exp_snq = 1'b1;
                        exp_to = 1'b0; exp_early = 1'b0;
                    end
                end
                P_WAIT: begin
                    if (qd_prev) begin
                        if (q == NQ - 1) begin
                            exp_ad = 1'b1; phase = P_IDLE;
                        end else begin
                            q++; hc = 0; exp_snq = 1'b1; phase = P_START;
                        end
                    end else begin
                        w++;
                        if (w == TO) begin
                            exp_to = 1'b1; phase = P_IDLE;
                        end
                    end
                end
                default: begin
                    if (qd_prev) exp_early = 1'b1;
                    if (phase == P_START || hc < 16) begin
                        phase = P_STREAM; exp_hv = !hold_prev;
                    end else begin
                        phase = P_WAIT; w = 0;
                        dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, TO - 1));
                    end
                end
            endcase
            exp_yv = exp_hv && (hc < 8);

            chk("start_new_q", start_new_q, exp_snq);
            chk("q_index", q_index, q);
            chk("H_in_valid", H_in_valid, exp_hv);
            chk("Y_in_valid", Y_in_valid, exp_yv);
            if (exp_hv) begin
                chk("H_data", {H_in_r, H_in_i}, {m_hr[hc], m_hi[hc]});
                if (exp_yv) chk("Y_data", {Y_in_r, Y_in_i}, {m_yr[hc], m_yi[hc]});
                hc++;
            end
            chk("busy", busy, phase != P_IDLE);
            chk("all_done", all_done, exp_ad);
            chk("err_timeout", err_timeout, exp_to);
            chk("err_early", err_early, exp_early);
            if (phase == P_IDLE) return;

            if (dir_hold) begin
                if (phase == P_STREAM && hc == 4 && held < 3) begin
                    hold = 1'b1; held++;
                end
            end else begin
                hold = ($urandom_range(0, 99) < hold_pct);
            end
            if (phase == P_WAIT && !no_done && w == dly) q_done = 1'b1;
            if (early && !early_done && phase == P_STREAM && hc == 5) begin
                q_done = 1'b1; early_done = 1'b1;
            end
            if (poke && !poked && phase == P_STREAM && hc == 2) begin
                poked = 1'b1; run = 1'b1;
                cfg_wr_en = 1'b1; cfg_wr_sel = 1'b0; cfg_wr_addr = 4'd0;
                cfg_wr_r = 32'h5A5A_0001; cfg_wr_i = 32'h5A5A_0002;
            end
            if (q == rst_q && phase == P_STREAM && hc == 9) begin
                rst = 1'b1; hold = 1'b0; q_done = 1'b0; run = 1'b0; cfg_wr_en = 1'b0;
                tick;
                rst = 1'b0;
                chk_zero("rst_mid");
                exp_to = 1'b0; exp_early = 1'b0;
                return;
            end
        end
        chk("sweep_budget", 64'd0, 64'd1);
    endtask

    initial begin
        rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_sel = 1'b0; cfg_wr_addr = 4'd0;
        cfg_wr_r = '0; cfg_wr_i = '0; run = 1'b0; hold = 1'b0; q_done = 1'b0;
        exp_to = 1'b0; exp_early = 1'b0;
        tick;
        tick;
        chk_zero("reset");
        rst = 1'b0;

        for (int k = 0; k < 16; k++) cfg_write(1'b0, 4'(k), k, -k);
        for (int k = 0; k < 8; k++) cfg_write(1'b1, 4'(k), 100 + k, 0);

        sweep(0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 5);
        sweep(0, 1'b1, 1'b0, 1'b0, -1, 1'b0, 5);
        sweep(0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 5);
        sweep(0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 3);

        for (int k = 0; k < 16; k++) cfg_write(1'b0, 4'(k), $urandom, $urandom);
        for (int k = 0; k < 8; k++) cfg_write(1'b1, 4'(k), $urandom, $urandom);

        sweep(30, 1'b0, 1'b0, 1'b0, -1, 1'b0, -1);
        sweep(20, 1'b0, 1'b0, 1'b0, 3, 1'b0, -1);
        sweep(20, 1'b0, 1'b0, 1'b0, -1, 1'b0, -1);
        sweep(0, 1'b0, 1'b0, 1'b0, -1, 1'b1, 2);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("idle_after_busy_run", {busy, start_new_q, H_in_valid}, 64'd0);
        end
        sweep(10, 1'b0, 1'b0, 1'b0, -1, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
